// File: rtl/i2c_slave_rx_frontend_if.sv
// Bus-side signal bundle for the I2C slave receive front end.
// The slave modport is the front end itself; master is the pin/consumer side.
interface i2c_slave_rx_frontend_if;
   logic       scl_in;
   logic       sda_in;
   logic       rx_ack;
   logic       sda_oe;
   logic       scl_s;
   logic       start_det;
   logic       stop_det;
   logic       addr_hit;
   logic       rw;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       byte_pend;

   modport slave (
      input  scl_in, sda_in, rx_ack,
      output sda_oe, scl_s, start_det, stop_det, addr_hit, rw, rx_data, rx_valid, byte_pend
   );

   modport master (
      output scl_in, sda_in, rx_ack,
      input  sda_oe, scl_s, start_det, stop_det, addr_hit, rw, rx_data, rx_valid, byte_pend
   );
endinterface

// File: rtl/i2c_slave_rx_frontend.sv
// I2C slave receive front end: sync SCL/SDA, START/STOP, address match, write bytes, ACK drive.
// Outputs registered one clk after the synchronised edge; no backpressure, byte_pend/rx_ack hand off bytes; I2C_GENERAL_CALL_EN also accepts address 8'h00.
module i2c_slave_rx_frontend #(
   parameter logic [6:0] SLV_ADDR    = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input logic                    clk,
   input logic                    reset,
   i2c_slave_rx_frontend_if.slave i2c
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_h_q;
   logic                   sda_h_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_h_q    <= 1'b1;
         sda_h_q    <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c.scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c.sda_in};
         scl_h_q    <= scl_sync_q[SYNC_STAGES-1];
         sda_h_q    <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;
   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise =  scl_s & ~scl_h_q;
   assign scl_fall = ~scl_s &  scl_h_q;
   assign sda_rise =  sda_s & ~sda_h_q;
   assign sda_fall = ~sda_s &  sda_h_q;
   assign start_c  = sda_fall & scl_s;
   assign stop_c   = sda_rise & scl_s;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shreg_q, shreg_d;
   logic       ack_hi_q, ack_hi_d;
   logic       sda_oe_q, sda_oe_d;
   logic       addr_hit_q, addr_hit_d;
   logic       rw_q, rw_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       byte_pend_q, byte_pend_d;
   logic       start_det_q, start_det_d;
   logic       stop_det_q, stop_det_d;

   logic [7:0] byte_w;
   logic       addr_match;
   logic       set_pend;
   assign byte_w = {shreg_q, sda_s};
`ifdef I2C_GENERAL_CALL_EN
   assign addr_match = (byte_w[7:1] == SLV_ADDR) || (byte_w == 8'h00);
`else
   assign addr_match = (byte_w[7:1] == SLV_ADDR);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         ack_hi_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         addr_hit_q  <= 1'b0;
         rw_q        <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         byte_pend_q <= 1'b0;
         start_det_q <= 1'b0;
         stop_det_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         ack_hi_q    <= ack_hi_d;
         sda_oe_q    <= sda_oe_d;
         addr_hit_q  <= addr_hit_d;
         rw_q        <= rw_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         byte_pend_q <= byte_pend_d;
         start_det_q <= start_det_d;
         stop_det_q  <= stop_det_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      ack_hi_d    = ack_hi_q;
      sda_oe_d    = sda_oe_q;
      addr_hit_d  = addr_hit_q;
      rw_d        = rw_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      start_det_d = 1'b0;
      stop_det_d  = 1'b0;
      set_pend    = 1'b0;

      // Bus conditions override whatever byte or ACK phase is in progress.
      if (start_c) begin
         start_det_d = 1'b1;
         addr_hit_d  = 1'b0;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         ack_hi_d    = 1'b0;
         state_d     = ADDR;
      end else if (stop_c) begin
         stop_det_d = 1'b1;
         addr_hit_d = 1'b0;
         sda_oe_d   = 1'b0;
         ack_hi_d   = 1'b0;
         state_d    = IDLE;
      end else begin
         case (state_q)
            ADDR, DATA: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[5:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == ADDR) begin
                        if (addr_match) begin
                           rw_d    = byte_w[0];
                           state_d = ADDR_ACK;
                        end else begin
                           state_d = IGNORE;
                        end
                     end else begin
                        rx_data_d  = byte_w;
                        rx_valid_d = 1'b1;
                        set_pend   = 1'b1;
                        state_d    = DATA_ACK;
                     end
                  end
               end
            end
            // First SCL fall starts the ACK bit, the second one ends it.
            ADDR_ACK, DATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_hi_q) begin
                     sda_oe_d   = 1'b1;
                     addr_hit_d = 1'b1;
                     ack_hi_d   = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     ack_hi_d = 1'b0;
                     state_d  = rw_q ? IGNORE : DATA;
                  end
               end
            end
            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end

      byte_pend_d = set_pend | (byte_pend_q & ~i2c.rx_ack);
   end

   assign i2c.sda_oe    = sda_oe_q;
   assign i2c.scl_s     = scl_s;
   assign i2c.start_det = start_det_q;
   assign i2c.stop_det  = stop_det_q;
   assign i2c.addr_hit  = addr_hit_q;
   assign i2c.rw        = rw_q;
   assign i2c.rx_data   = rx_data_q;
   assign i2c.rx_valid  = rx_valid_q;
   assign i2c.byte_pend = byte_pend_q;

endmodule

// File: tb/tb_i2c_slave_rx_frontend.sv
// Bench for i2c_slave_rx_frontend: bit-banged I2C master with wired-AND SDA
// and a transaction-level model of what the slave should accept.
module tb_i2c_slave_rx_frontend;
   localparam int Q = 8;
`ifdef I2C_GENERAL_CALL_EN
   localparam bit GC = 1'b1;
`else
   localparam bit GC = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic scl_drv = 1'b1;
   logic sda_drv = 1'b1;
   logic rx_ack_drv = 1'b0;
   always #5 clk = ~clk;

   i2c_slave_rx_frontend_if bus_if();
   assign bus_if.scl_in = scl_drv;
   assign bus_if.sda_in = sda_drv & ~bus_if.sda_oe;
   assign bus_if.rx_ack = rx_ack_drv;

   i2c_slave_rx_frontend #(.SLV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk  (clk),
      .reset(reset),
      .i2c  (bus_if)
   );

   int n_vec = 0;
   int n_err = 0;
   int start_cnt = 0, stop_cnt = 0, valid_cnt = 0;
   logic [7:0] last_rx = 8'h00;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus_if.start_det) start_cnt++;
         if (bus_if.stop_det)  stop_cnt++;
         if (bus_if.rx_valid) begin
            valid_cnt++;
            last_rx = bus_if.rx_data;
         end
      end
   end

   // Transaction model: 0 = not listening, 1 = next byte is an address, 2 = write data
   int         m_mode = 0;
   bit         m_hit = 1'b0, m_rw = 1'b0, m_pend = 1'b0;
   logic [7:0] m_data = 8'h00;

   task automatic model_start();
      m_mode = 1; m_hit = 1'b0;
   endtask
   task automatic model_stop();
      m_mode = 0; m_hit = 1'b0;
   endtask
   task automatic model_byte(input logic [7:0] b, output bit ack, output bit vld);
      ack = 1'b0; vld = 1'b0;
      if (m_mode == 1) begin
         if (b[7:1] == 7'h50 || (GC && b == 8'h00)) begin
            ack = 1'b1; m_hit = 1'b1; m_rw = b[0];
            m_mode = b[0] ? 0 : 2;
         end else begin
            m_mode = 0;
         end
      end else if (m_mode == 2) begin
         ack = 1'b1; vld = 1'b1; m_data = b; m_pend = 1'b1;
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask
   task automatic bus_start();
      if (!scl_drv) begin
         sda_drv = 1'b1; wait_q();
         scl_drv = 1'b1; wait_q();
      end
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b0; wait_q();
      model_start();
   endtask
   task automatic bus_stop();
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b1; wait_q();
      sda_drv = 1'b1; wait_q(); wait_q();
      model_stop();
   endtask
   task automatic send_bit(input logic b);
      sda_drv = b; wait_q();
      scl_drv = 1'b1; wait_q(); wait_q();
      scl_drv = 1'b0; wait_q();
   endtask
   // Sends one byte plus the ACK slot; ack is sda_oe held through the 9th SCL high.
   task automatic xfer(input logic [7:0] b, output bit ack, output bit oe_after,
                       output bit exp_ack, output bit exp_vld, output int vdelta);
      int v0;
      v0 = valid_cnt;
      model_byte(b, exp_ack, exp_vld);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_drv = 1'b1; wait_q();
      scl_drv = 1'b1; wait_q();
      ack = bus_if.sda_oe; wait_q();
      ack = ack & bus_if.sda_oe;
      scl_drv = 1'b0; wait_q();
      oe_after = bus_if.sda_oe;
      vdelta = valid_cnt - v0;
   endtask
   task automatic pulse_ack();
      @(negedge clk) rx_ack_drv = 1'b1;
      @(negedge clk) rx_ack_drv = 1'b0;
      m_pend = 1'b0;
   endtask

   task automatic test_reset();
      int s0, p0;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_vec++; if (bus_if.sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", bus_if.sda_oe); end
      n_vec++; if (bus_if.byte_pend !== 1'b0) begin n_err++; $display("FAIL reset_byte_pend: got %b want 0", bus_if.byte_pend); end
      n_vec++; if (bus_if.scl_s !== 1'b1) begin n_err++; $display("FAIL reset_scl_s: got %b want 1", bus_if.scl_s); end
      n_vec++; if ({bus_if.addr_hit, bus_if.rw, bus_if.rx_valid, bus_if.rx_data} !== 11'd0) begin
         n_err++; $display("FAIL reset_outputs: got hit=%b rw=%b vld=%b data=%h want all 0",
                           bus_if.addr_hit, bus_if.rw, bus_if.rx_valid, bus_if.rx_data);
      end
      s0 = start_cnt; p0 = stop_cnt;
      repeat (50) @(negedge clk);
      n_vec++; if (start_cnt - s0 !== 0 || stop_cnt - p0 !== 0) begin
         n_err++; $display("FAIL reset_idle_pulses: got start=%0d stop=%0d want 0 0", start_cnt - s0, stop_cnt - p0);
      end
   endtask

   task automatic test_addr_write();
      bit ack, oe, eack, evld; int vd, s0, p0;
      s0 = start_cnt;
      bus_start();
      n_vec++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL aw_start_det: got %0d pulses want 1", start_cnt - s0); end
      xfer(8'hA0, ack, oe, eack, evld, vd);
      n_vec++; if (ack !== eack) begin n_err++; $display("FAIL aw_addr_ack: got %b want %b", ack, eack); end
      n_vec++; if (oe !== 1'b0) begin n_err++; $display("FAIL aw_addr_release: got sda_oe=%b want 0", oe); end
      n_vec++; if (bus_if.addr_hit !== m_hit || bus_if.rw !== m_rw) begin
         n_err++; $display("FAIL aw_hit_rw: got hit=%b rw=%b want hit=%b rw=%b", bus_if.addr_hit, bus_if.rw, m_hit, m_rw);
      end
      xfer(8'h3C, ack, oe, eack, evld, vd);
      n_vec++; if (ack !== eack) begin n_err++; $display("FAIL aw_data_ack: got %b want %b", ack, eack); end
      n_vec++; if (vd !== int'(evld)) begin n_err++; $display("FAIL aw_rx_valid: got %0d pulses want %0d", vd, evld); end
      n_vec++; if (last_rx !== m_data || bus_if.rx_data !== m_data) begin
         n_err++; $display("FAIL aw_rx_data: got %h/%h want %h", last_rx, bus_if.rx_data, m_data);
      end
      n_vec++; if (bus_if.byte_pend !== m_pend) begin n_err++; $display("FAIL aw_pend_set: got %b want %b", bus_if.byte_pend, m_pend); end
      pulse_ack();
      n_vec++; if (bus_if.byte_pend !== m_pend) begin n_err++; $display("FAIL aw_pend_clear: got %b want %b", bus_if.byte_pend, m_pend); end
      // Two bytes with no rx_ack in between: overrun keeps pend and overwrites data
      xfer(8'h11, ack, oe, eack, evld, vd);
      xfer(8'h22, ack, oe, eack, evld, vd);
      n_vec++; if (last_rx !== m_data || bus_if.byte_pend !== m_pend) begin
         n_err++; $display("FAIL aw_overrun: got data=%h pend=%b want data=%h pend=%b", last_rx, bus_if.byte_pend, m_data, m_pend);
      end
      p0 = stop_cnt;
      bus_stop();
      n_vec++; if (stop_cnt - p0 !== 1) begin n_err++; $display("FAIL aw_stop_det: got %0d pulses want 1", stop_cnt - p0); end
      n_vec++; if (bus_if.addr_hit !== m_hit || bus_if.byte_pend !== m_pend) begin
         n_err++; $display("FAIL aw_after_stop: got hit=%b pend=%b want hit=%b pend=%b", bus_if.addr_hit, bus_if.byte_pend, m_hit, m_pend);
      end
      pulse_ack();
      n_vec++; if (bus_if.byte_pend !== m_pend) begin n_err++; $display("FAIL aw_pend_clear2: got %b want %b", bus_if.byte_pend, m_pend); end
   endtask

   task automatic test_addr_miss();
      bit ack, oe, eack, evld; int vd;
      bus_start();
      xfer(8'hA2, ack, oe, eack, evld, vd);
      n_vec++; if (ack !== eack) begin n_err++; $display("FAIL miss_ack: got %b want %b", ack, eack); end
      n_vec++; if (bus_if.addr_hit !== m_hit) begin n_err++; $display("FAIL miss_hit: got %b want %b", bus_if.addr_hit, m_hit); end
      xfer(8'hFF, ack, oe, eack, evld, vd);
      n_vec++; if (vd !== int'(evld) || ack !== eack) begin
         n_err++; $display("FAIL miss_data: got vld=%0d ack=%b want vld=%0d ack=%b", vd, ack, evld, eack);
      end
      bus_stop();
   endtask

   task automatic test_repeated_start();
      bit ack, oe, eack, evld; int vd, s0, p0;
      bus_start();
      xfer(8'hA0, ack, oe, eack, evld, vd);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      s0 = start_cnt;
      bus_start();
      n_vec++; if (start_cnt - s0 !== 1 || bus_if.addr_hit !== m_hit) begin
         n_err++; $display("FAIL rs_start: got pulses=%0d hit=%b want 1 %b", start_cnt - s0, bus_if.addr_hit, m_hit);
      end
      xfer(8'hA1, ack, oe, eack, evld, vd);
      n_vec++; if (ack !== eack || bus_if.rw !== m_rw || bus_if.addr_hit !== m_hit) begin
         n_err++; $display("FAIL rs_addr: got ack=%b rw=%b hit=%b want %b %b %b", ack, bus_if.rw, bus_if.addr_hit, eack, m_rw, m_hit);
      end
      xfer(8'h55, ack, oe, eack, evld, vd);
      n_vec++; if (vd !== int'(evld) || ack !== eack) begin
         n_err++; $display("FAIL rs_ignore: got vld=%0d ack=%b want %0d %b", vd, ack, evld, eack);
      end
      p0 = stop_cnt;
      bus_stop();
      n_vec++; if (stop_cnt - p0 !== 1 || bus_if.addr_hit !== m_hit) begin
         n_err++; $display("FAIL rs_stop: got pulses=%0d hit=%b want 1 %b", stop_cnt - p0, bus_if.addr_hit, m_hit);
      end
   endtask

   task automatic test_general_call();
      bit ack, oe, eack, evld; int vd;
      bus_start();
      xfer(8'h00, ack, oe, eack, evld, vd);
      n_vec++; if (ack !== eack || bus_if.addr_hit !== m_hit) begin
         n_err++; $display("FAIL gc_addr: got ack=%b hit=%b want %b %b", ack, bus_if.addr_hit, eack, m_hit);
      end
      xfer(8'h5A, ack, oe, eack, evld, vd);
      n_vec++; if (vd !== int'(evld) || ack !== eack) begin
         n_err++; $display("FAIL gc_data: got vld=%0d ack=%b want %0d %b", vd, ack, evld, eack);
      end
      bus_stop();
      if (m_pend) pulse_ack();
   endtask

   task automatic test_random();
      bit ack, oe, eack, evld; int vd, nb, ending;
      logic [7:0] a;
      for (int t = 0; t < 16; t++) begin
         if (t == 0 || ending != 0) bus_start();
         case ($urandom_range(0, 4))
            0: a = 8'hA0;
            1: a = 8'hA1;
            2: a = 8'hA2;
            3: a = 8'h00;
            default: a = 8'($urandom);
         endcase
         xfer(a, ack, oe, eack, evld, vd);
         n_vec++; if (ack !== eack || oe !== 1'b0 || bus_if.addr_hit !== m_hit || bus_if.rw !== m_rw) begin
            n_err++; $display("FAIL rnd_addr %h: got ack=%b oe=%b hit=%b rw=%b want %b 0 %b %b",
                              a, ack, oe, bus_if.addr_hit, bus_if.rw, eack, m_hit, m_rw);
         end
         nb = $urandom_range(0, 3);
         for (int k = 0; k < nb; k++) begin
            a = 8'($urandom);
            xfer(a, ack, oe, eack, evld, vd);
            n_vec++; if (ack !== eack || vd !== int'(evld) || bus_if.byte_pend !== m_pend) begin
               n_err++; $display("FAIL rnd_data %h: got ack=%b vld=%0d pend=%b want %b %0d %b",
                                 a, ack, vd, bus_if.byte_pend, eack, evld, m_pend);
            end
            n_vec++; if (evld && last_rx !== m_data) begin
               n_err++; $display("FAIL rnd_rx_data: got %h want %h", last_rx, m_data);
            end
            if ($urandom_range(0, 1) == 1) begin
               pulse_ack();
               n_vec++; if (bus_if.byte_pend !== m_pend) begin
                  n_err++; $display("FAIL rnd_pend_ack: got %b want %b", bus_if.byte_pend, m_pend);
               end
            end
         end
         ending = (t == 15) ? 0 : $urandom_range(0, 2);
         if (ending == 0) begin
            bus_stop();
         end else if (ending == 1) begin
            for (int k = 0; k < $urandom_range(1, 7); k++) send_bit(1'($urandom));
         end
      end
      if (m_pend) pulse_ack();
      n_vec++; if (bus_if.byte_pend !== m_pend || bus_if.addr_hit !== m_hit) begin
         n_err++; $display("FAIL rnd_final: got pend=%b hit=%b want %b %b", bus_if.byte_pend, bus_if.addr_hit, m_pend, m_hit);
      end
   endtask

   initial begin
      test_reset();
      test_addr_write();
      test_addr_miss();
      test_repeated_start();
      test_general_call();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
